ram2p_fifo_ctrl: RTL and testbench
==================================

// Module: ram2p_fifo_ctrl
// PURPOSE
//  Valid/ready FIFO controller that sequences one GenRam2P16D116W (16x116 two-port RAM, 1-cycle registered read).
//  Owns write/read pointers, occupancy and a 2-entry output skid stage.
//  Presents first-word-fall-through output to the downstream DMA pipeline. The RAM instance sits outside this block.
// PARAMETERS
//  DEPTH   16   RAM entries; power of two
//  ADDR_W  4    log2(DEPTH)
//  DATA_W  116  word width
// PORTS
//  clockCore     in   1         core clock; all logic rising-edge
//  resetCoreN    in   1         asynchronous active-low reset
//  flush         in   1         sync clear of all contents; wins over push/pop
//  inValid       in   1         push request
//  inReady       out  1         push accepted when inValid&inReady
//  inData        in   DATA_W    push data
//  outValid      out  1         head word available
//  outReady      in   1         pop when outValid&outReady
//  outData       out  DATA_W    head word (stage slot 0)
//  level         out  ADDR_W+2  total words held (RAM + in-flight + stage), 0..DEPTH+2
//  ramEnableWrite  out 1        to RAM enableWrite
//  ramAddressWrite out ADDR_W   to RAM addressWrite
//  ramWriteData    out DATA_W   to RAM writeData
//  ramEnableRead   out 1        to RAM enableRead
//  ramAddressRead  out ADDR_W   to RAM addressRead
//  ramReadData     in  DATA_W   from RAM readData, valid 1 cycle after ramEnableRead
// BEHAVIOUR
//  Reset (async, resetCoreN=0): wrPtr=rdPtr=0, ramCount=0, inFlight=0, stageCount=0. Outputs: inReady=1,
//   outValid=0, outData=0, level=0, ramEnableWrite=0, ramEnableRead=0. Reset mid-transfer discards everything.
//  Write: inReady = (ramCount!=DEPTH) & ~flush. Push -> ramEnableWrite=1, ramAddressWrite=wrPtr,
//   ramWriteData=inData (combinational), wrPtr+1 mod DEPTH (natural wrap), ramCount+1.
//  Read issue: ramEnableRead = (ramCount!=0) & (stageCount+inFlight - popThisCycle < 2) & ~flush;
//   ramAddressRead=rdPtr; rdPtr+1 mod DEPTH, ramCount-1, inFlight<=1 next cycle.
//  Return: cycle after issue, ramReadData written into first free stage slot; inFlight<=0 unless reissued.
//  Stage: 2-slot queue; outData=slot0, outValid=(stageCount!=0). Pop shifts slot1->slot0; pop and return in
//   same cycle legal (return lands in correct slot, order preserved).
//  Simultaneous push+issue same cycle: ramCount unchanged. Same-address read/write impossible (empty/full gated).
//  Latency: word pushed into empty FIFO appears on outData 3 cycles later (write, read issue, return).
//  Full: ramCount==DEPTH -> inReady=0; level may reach DEPTH+2. Push with inReady=0 ignored, no state change.
//  Empty: outValid=0; outReady ignored; no RAM read issued.
//  level = ramCount + inFlight + stageCount, registered, updated every cycle.
//  flush: next cycle all counters/pointers 0, stage cleared, returning in-flight data dropped;
//   no RAM enable asserted during the flush cycle.
//  outData holds value while outValid&~outReady (stable under backpressure).
// TESTING
//  1 Reset: hold resetCoreN=0 mid-stream -> inReady=1, outValid=0, level=0 asynchronously, no RAM enables.
//  2 Single word: push 116'h1 into empty at cycle 0, outReady=1 -> outValid=1, outData=116'h1 at cycle 3, level 1->0.
//  3 Fill: push 0..19 with outReady=0 -> inReady drops after 18 accepted (level=18), words 0..17 popped in order.
//  4 Wrap: 40 pushes/pops at full rate with random outReady -> output sequence equals input, pointers wrap twice.
//  5 Backpressure: outValid=1, outReady=0 for 5 cycles -> outData stable, no loss when released.
//  6 Flush with 10 words + read in flight -> next cycle level=0, outValid=0; later push 116'hA emerges alone.

Source files
------------

// File: rtl/ram2p_fifo_ctrl.sv
// Valid/ready FIFO controller sequencing an external 16x116 two-port RAM with
// 1-cycle read latency; first-word-fall-through output via a 2-slot skid stage.
module ram2p_fifo_ctrl #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 116
) (
  input  logic              clockCore,
  input  logic              resetCoreN,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [ADDR_W+1:0] level,
  output logic              ramEnableWrite,
  output logic [ADDR_W-1:0] ramAddressWrite,
  output logic [DATA_W-1:0] ramWriteData,
  output logic              ramEnableRead,
  output logic [ADDR_W-1:0] ramAddressRead,
  input  logic [DATA_W-1:0] ramReadData
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned LVL_W = ADDR_W + 2;

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_ram_count;
  logic              r_in_flight;
  logic [1:0]        r_stage_count;
  logic [DATA_W-1:0] r_slot0, r_slot1;
  logic [LVL_W-1:0]  r_level;

  logic              w_push, w_pop, w_issue;
  logic [2:0]        w_occ_after_pop;
  logic [1:0]        w_cnt_after_pop;
  logic [ADDR_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_ram_count_nxt;
  logic              w_in_flight_nxt;
  logic [1:0]        w_stage_count_nxt;
  logic [DATA_W-1:0] w_slot0_nxt, w_slot1_nxt;
  logic [LVL_W-1:0]  w_level_nxt;

  // Handshakes and RAM port drive
  assign inReady         = (r_ram_count != CNT_W'(DEPTH)) & ~flush;
  assign w_push          = inValid & inReady;
  assign w_pop           = (r_stage_count != 2'd0) & outReady & ~flush;
  assign w_occ_after_pop = 3'(r_stage_count) + 3'(r_in_flight) - 3'(w_pop);
  assign w_issue         = (r_ram_count != CNT_W'(0)) & (w_occ_after_pop < 3'd2) & ~flush;

  assign ramEnableWrite  = w_push;
  assign ramAddressWrite = r_wr_ptr;
  assign ramWriteData    = inData;
  assign ramEnableRead   = w_issue;
  assign ramAddressRead  = r_rd_ptr;

  assign outValid = (r_stage_count != 2'd0);
  assign outData  = r_slot0;
  assign level    = r_level;

  // Next-state: pop shifts the stage first, then the returning word fills the first free slot
  always_comb begin
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_ram_count_nxt   = r_ram_count;
    w_in_flight_nxt   = 1'b0;
    w_stage_count_nxt = r_stage_count;
    w_slot0_nxt       = r_slot0;
    w_slot1_nxt       = r_slot1;
    w_cnt_after_pop   = r_stage_count - 2'(w_pop);

    if (flush) begin
      w_wr_ptr_nxt      = '0;
      w_rd_ptr_nxt      = '0;
      w_ram_count_nxt   = '0;
      w_stage_count_nxt = '0;
      w_slot0_nxt       = '0;
      w_slot1_nxt       = '0;
    end else begin
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
      if (w_issue) w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(1);
      w_ram_count_nxt   = r_ram_count + CNT_W'(w_push) - CNT_W'(w_issue);
      w_in_flight_nxt   = w_issue;
      w_stage_count_nxt = w_cnt_after_pop;
      if (w_pop) w_slot0_nxt = r_slot1;
      if (r_in_flight) begin
        if (w_cnt_after_pop == 2'd0) w_slot0_nxt = ramReadData;
        else                         w_slot1_nxt = ramReadData;
        w_stage_count_nxt = w_cnt_after_pop + 2'd1;
      end
    end
    w_level_nxt = LVL_W'(w_ram_count_nxt) + LVL_W'(w_in_flight_nxt) + LVL_W'(w_stage_count_nxt);
  end

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_count   <= '0;
      r_in_flight   <= 1'b0;
      r_stage_count <= '0;
      r_slot0       <= '0;
      r_slot1       <= '0;
      r_level       <= '0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_ram_count   <= w_ram_count_nxt;
      r_in_flight   <= w_in_flight_nxt;
      r_stage_count <= w_stage_count_nxt;
      r_slot0       <= w_slot0_nxt;
      r_slot1       <= w_slot1_nxt;
      r_level       <= w_level_nxt;
    end
  end

endmodule

// File: tb/tb_ram2p_fifo_ctrl.sv
// Directed bench for ram2p_fifo_ctrl with a behavioural 16x116 two-port RAM.
module tb_ram2p_fifo_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [115:0] in_data, out_data, ram_wdata, ram_rdata;
  logic [5:0]   level;
  logic         ram_we, ram_re;
  logic [3:0]   ram_waddr, ram_raddr;
  logic [115:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram2p_fifo_ctrl dut (
    .clockCore(clk), .resetCoreN(rst_n), .flush(flush),
    .inValid(in_valid), .inReady(in_ready), .inData(in_data),
    .outValid(out_valid), .outReady(out_ready), .outData(out_data), .level(level),
    .ramEnableWrite(ram_we), .ramAddressWrite(ram_waddr), .ramWriteData(ram_wdata),
    .ramEnableRead(ram_re), .ramAddressRead(ram_raddr), .ramReadData(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Pops until n words seen (or budget runs out), checking each against base+i
  task automatic drain(input string tag, input logic [115:0] base, input int n);
    int got_n = 0;
    for (int c = 0; c < 100 && got_n < n; c++) begin
      out_ready = 1'b1; #1;
      if (out_valid) begin
        chk(tag, out_data, base + 116'(got_n));
        got_n++;
      end
      step();
    end
    out_ready = 1'b0;
    chk({tag, "_count"}, 128'(got_n), 128'(n));
    chk({tag, "_level"}, 128'(level), 128'd0);
  endtask

  initial begin
    logic [115:0] sb[$];
    logic [115:0] exp_w;
    int acc, pushed, popped;
    ram_rdata = '0;

    // 1: asynchronous reset in the middle of traffic
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 116'(i + 50); step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_inready", 128'(in_ready), 128'd1);
    chk("rst_outvalid", 128'(out_valid), 128'd0);
    chk("rst_level", 128'(level), 128'd0);
    chk("rst_outdata", 128'(out_data), 128'd0);
    chk("rst_re", 128'(ram_re), 128'd0);
    chk("rst_we", 128'(ram_we), 128'd0);
    do_reset();

    // 2: single word, 3-cycle fall-through latency
    in_valid = 1'b1; in_data = 116'h1; out_ready = 1'b1; #1;
    chk("single_we", 128'(ram_we), 128'd1);
    chk("single_waddr", 128'(ram_waddr), 128'd0);
    step(); in_valid = 1'b0; #1;
    chk("single_c1_level", 128'(level), 128'd1);
    chk("single_c1_re", 128'(ram_re), 128'd1);
    chk("single_c1_valid", 128'(out_valid), 128'd0);
    step();
    chk("single_c2_valid", 128'(out_valid), 128'd0);
    step();
    chk("single_c3_valid", 128'(out_valid), 128'd1);
    chk("single_c3_data", 128'(out_data), 128'h1);
    chk("single_c3_level", 128'(level), 128'd1);
    step();
    chk("single_c4_valid", 128'(out_valid), 128'd0);
    chk("single_c4_level", 128'(level), 128'd0);
    out_ready = 1'b0;

    // 3: fill with no pops; 18 words fit (16 RAM + 2 stage)
    do_reset();
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (acc < 20); in_data = 116'(acc); #1;
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0; #1;
    chk("fill_accepted", 128'(acc), 128'd18);
    chk("fill_level", 128'(level), 128'd18);
    chk("fill_inready", 128'(in_ready), 128'd0);
    drain("fill_order", 116'd0, 18);

    // 4: 40 words with random backpressure, pointers wrap twice
    do_reset();
    pushed = 0; popped = 0;
    for (int c = 0; c < 400 && popped < 40; c++) begin
      in_valid  = (pushed < 40);
      in_data   = {20'(pushed), 96'h0123456789ABCDEF00112233};
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        chk("wrap_waddr", 128'(ram_waddr), 128'(pushed % 16));
        sb.push_back(in_data);
        pushed++;
      end
      if (out_valid && out_ready) begin
        exp_w = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("wrap_data", 128'(out_data), 128'(exp_w));
        popped++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_popped", 128'(popped), 128'd40);
    chk("wrap_level", 128'(level), 128'd0);

    // 5: head word stable under backpressure, nothing lost afterwards
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 116'h0B00 + 116'(i); step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", 128'(out_data), 128'h0B00);
      step();
    end
    drain("bp_order", 116'h0B00, 3);

    // 6: flush with 10 words stored and a read in flight
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 116'h100 + 116'(i); step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("flush_pre_level", 128'(level), 128'd10);
    out_ready = 1'b1; #1;
    chk("flush_pre_re", 128'(ram_re), 128'd1);
    step();
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 116'h123; #1;
    chk("flush_re", 128'(ram_re), 128'd0);
    chk("flush_we", 128'(ram_we), 128'd0);
    chk("flush_inready", 128'(in_ready), 128'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_level", 128'(level), 128'd0);
    chk("flush_valid", 128'(out_valid), 128'd0);
    chk("flush_inready_after", 128'(in_ready), 128'd1);
    in_valid = 1'b1; in_data = 116'hA; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    step();
    chk("flush_c2_valid", 128'(out_valid), 128'd0);
    step();
    chk("flush_a_valid", 128'(out_valid), 128'd1);
    chk("flush_a_data", 128'(out_data), 128'hA);
    step();
    chk("flush_a_alone", 128'(out_valid), 128'd0);
    chk("flush_a_level", 128'(level), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
